// File: rtl/uart_msg_pkg.sv
// Shared definitions for the UART message framing blocks (RX and TX sides).
// Holds the frame FSM state encoding and the default frame start byte.
`timescale 1ns/1ps

package uart_msg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_PAY   = 3'd2,
        ST_CHK   = 3'd3,
        ST_VALID = 3'd4,
        ST_ERR   = 3'd5
    } state_e;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

endpackage

// File: rtl/rx_msg_shifter.sv
// Payload shadow register plus running XOR checksum accumulator.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clear_i     - zero shadow register and accumulator (start of frame)
//   shift_i     - shift data_i into the LSB byte and XOR it into the accumulator
//   data_i      - received payload byte
//   shadow_o    - payload so far, first byte ends up in the MSBs
//   acc_o       - XOR of all bytes shifted since the last clear
`timescale 1ns/1ps

module rx_msg_shifter #(
    parameter int unsigned MSG_LEN = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear_i,
    input  logic                   shift_i,
    input  logic [7:0]             data_i,
    output logic [8*MSG_LEN-1:0]   shadow_o,
    output logic [7:0]             acc_o
);

    logic [8*MSG_LEN-1:0] shadow_q;
    logic [7:0]           acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            acc_q    <= '0;
        end else if (clear_i) begin
            shadow_q <= '0;
            acc_q    <= '0;
        end else if (shift_i) begin
            shadow_q <= {shadow_q[8*MSG_LEN-9:0], data_i};
            acc_q    <= acc_q ^ data_i;
        end
    end

    assign shadow_o = shadow_q;
    assign acc_o    = acc_q;

endmodule

// File: rtl/state_machine_rx.sv
// Frame receiver FSM: HEADER, MSG_LEN payload bytes, XOR checksum byte.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   Enable       - permits frame reception (honoured only between frames)
//   Rx_Done      - one-cycle strobe, Rx_Data valid
//   Rx_Data      - received byte
//   Timer_Done   - inter-byte timeout from the external timer
//   Start_Rx     - enables the external byte receiver
//   Start_Timer  - runs the external timer; low clears it
//   Msg_Data     - last good payload, first byte in the MSBs
//   Msg_Valid    - one-cycle pulse, good frame
//   Msg_Error    - one-cycle pulse, bad checksum or timeout
//   Busy         - inside a frame (payload or checksum phase)
// All outputs are registered from the next-state decode.
`timescale 1ns/1ps

module state_machine_rx
    import uart_msg_pkg::*;
#(
    parameter int unsigned MSG_LEN = 4,
    parameter logic [7:0]  HEADER  = HEADER_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 Enable,
    input  logic                 Rx_Done,
    input  logic [7:0]           Rx_Data,
    input  logic                 Timer_Done,
    output logic                 Start_Rx,
    output logic                 Start_Timer,
    output logic [8*MSG_LEN-1:0] Msg_Data,
    output logic                 Msg_Valid,
    output logic                 Msg_Error,
    output logic                 Busy
);

    localparam int unsigned    CntW    = $clog2(MSG_LEN + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(MSG_LEN - 1);

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 clear, shift, accept;
    logic [8*MSG_LEN-1:0] shadow;
    logic [7:0]           acc;

    rx_msg_shifter #(
        .MSG_LEN (MSG_LEN)
    ) u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (clear),
        .shift_i  (shift),
        .data_i   (Rx_Data),
        .shadow_o (shadow),
        .acc_o    (acc)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clear   = 1'b0;
        shift   = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (Enable) state_d = ST_HDR;
            end
            ST_HDR: begin
                if (!Enable) begin
                    state_d = ST_IDLE;
                end else if (Rx_Done && Rx_Data == HEADER) begin
                    state_d = ST_PAY;
                    cnt_d   = '0;
                    clear   = 1'b1;
                    accept  = 1'b1;
                end
            end
            ST_PAY: begin
                // A byte beats a coincident timeout.
                if (Rx_Done) begin
                    shift  = 1'b1;
                    accept = 1'b1;
                    cnt_d  = cnt_q + CntW'(1);
                    if (cnt_q == LastCnt) state_d = ST_CHK;
                end else if (Timer_Done) begin
                    state_d = ST_ERR;
                end
            end
            ST_CHK: begin
                if (Rx_Done) begin
                    accept  = 1'b1;
                    state_d = (Rx_Data == acc) ? ST_VALID : ST_ERR;
                end else if (Timer_Done) begin
                    state_d = ST_ERR;
                end
            end
            ST_VALID, ST_ERR: begin
                state_d = Enable ? ST_HDR : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            Start_Rx    <= 1'b0;
            Start_Timer <= 1'b0;
            Busy        <= 1'b0;
            Msg_Valid   <= 1'b0;
            Msg_Error   <= 1'b0;
            Msg_Data    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            Start_Rx    <= (state_d inside {ST_HDR, ST_PAY, ST_CHK});
            // Drop the timer for one cycle after each accepted byte to restart it.
            Start_Timer <= (state_d inside {ST_PAY, ST_CHK}) && !accept;
            Busy        <= (state_d inside {ST_PAY, ST_CHK});
            Msg_Valid   <= (state_d == ST_VALID);
            Msg_Error   <= (state_d == ST_ERR);
            if (state_d == ST_VALID) Msg_Data <= shadow;
        end
    end

endmodule

// File: doc/state_machine_rx.md
STATE_MACHINE_RX -- requirements
Module: state_machine_rx

Interface
REQ-001 SHALL have parameter MSG_LEN, default 4, giving the payload bytes per frame (legal range 2..8).
REQ-002 SHALL have parameter HEADER, default 8'hA5, giving the frame start byte.
REQ-003 SHALL have port clk, input, 1, the single system clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port Enable, input, 1, level that permits frame reception.
REQ-006 SHALL have port Rx_Done, input, 1, one-cycle pulse from the byte receiver meaning Rx_Data is valid.
REQ-007 SHALL have port Rx_Data, input, 8, the received byte, valid only while Rx_Done=1.
REQ-008 SHALL have port Timer_Done, input, 1, inter-byte timeout expired, from the external timer.
REQ-009 SHALL have port Start_Rx, output, 1, level that enables the byte receiver.
REQ-010 SHALL have port Start_Timer, output, 1, level that runs the external timer; low clears it.
REQ-011 SHALL have port Msg_Data, output, 8*MSG_LEN, last valid payload with the first byte received in the MSBs.
REQ-012 SHALL have port Msg_Valid, output, 1, one-cycle pulse marking a good frame.
REQ-013 SHALL have port Msg_Error, output, 1, one-cycle pulse marking a bad checksum or a timeout.
REQ-014 SHALL have port Busy, output, 1, high while the block is inside a frame, i.e. in ST_PAY or ST_CHK.

Function
REQ-015 Frame format SHALL be HEADER, then MSG_LEN payload bytes, then one checksum byte equal to the XOR of all payload bytes.
REQ-016 States SHALL be ST_IDLE, ST_HDR, ST_PAY, ST_CHK, ST_VALID and ST_ERR.
REQ-017 ST_IDLE: all outputs low; Enable=1 moves to ST_HDR; Rx_Done is ignored.
REQ-018 ST_HDR: Start_Rx=1 and Start_Timer=0; Rx_Done with Rx_Data==HEADER moves to ST_PAY and clears the byte count and XOR accumulator; any other byte is discarded; Enable=0 moves to ST_IDLE.
REQ-019 ST_PAY: Start_Rx=1; each Rx_Done shifts Rx_Data into the payload shadow register, XORs it into the accumulator and increments the count; the byte completing count MSG_LEN moves to ST_CHK.
REQ-020 In ST_PAY and ST_CHK, Start_Timer SHALL be 1, except for exactly one cycle low after each accepted byte (HEADER included) to restart the timer.
REQ-021 ST_CHK: Rx_Done with Rx_Data==accumulator moves to ST_VALID; a mismatching byte moves to ST_ERR.
REQ-022 Timer_Done in ST_PAY or ST_CHK without Rx_Done moves to ST_ERR; when Rx_Done and Timer_Done coincide, the byte SHALL win.
REQ-023 ST_VALID lasts one cycle: Msg_Valid=1, Msg_Data loaded from the shadow register in the same cycle; next state is ST_HDR if Enable=1, else ST_IDLE.
REQ-024 ST_ERR lasts one cycle: Msg_Error=1, Msg_Data unchanged; next state is as in ST_VALID.
REQ-025 Latency SHALL be one cycle: Msg_Valid or Msg_Error rises on the cycle after the checksum-byte Rx_Done or the Timer_Done.
REQ-026 Enable=0 in ST_PAY or ST_CHK SHALL NOT abort the frame; it is honoured at frame end.
REQ-027 Byte count width SHALL be $clog2(MSG_LEN+1); count never wraps, because the transition occurs at MSG_LEN.
REQ-028 Rx_Done arriving in ST_VALID or ST_ERR SHALL be dropped.

Reset
REQ-029 rst_n=0 SHALL asynchronously force ST_IDLE and clear the count, accumulator, shadow register and Msg_Data to 0, with all outputs low.
REQ-030 Reset mid-frame SHALL discard the partial frame; no Msg_Valid or Msg_Error pulse is issued.

Structure
REQ-031 State encoding and the default HEADER constant SHALL reside in shared package uart_msg_pkg, which the TX side also uses.
REQ-032 Payload shift register plus XOR accumulator SHALL be sub-module rx_msg_shifter, controlled by clear/shift strobes from the FSM.
REQ-033 The timer and byte receiver SHALL remain external.

Verification
REQ-034 MSG_LEN=4; bytes A5,11,22,33,44,44 -> Msg_Valid pulse one cycle after the last Rx_Done, Msg_Data=32'h11223344, Msg_Error never asserts.
REQ-035 Bytes A5,11,22,33,44,45 -> Msg_Error pulse, Msg_Data keeps its previous value (0 after reset).
REQ-036 Bytes 00,FF,A5,01,02,03,04,04 -> 00 and FF ignored, Msg_Valid with Msg_Data=32'h01020304.
REQ-037 Bytes A5,11,22 then Timer_Done -> Msg_Error, return to ST_HDR; a following good frame -> Msg_Valid.
REQ-038 Rx_Done(0x44) coincident with Timer_Done on the last payload byte -> byte accepted, no error.
REQ-039 rst_n low after A5,11 -> all outputs 0 immediately; after release, a good frame -> Msg_Valid.
